// File: rtl/k12a_alu_seq_pkg.sv
// rtl/k12a_alu_seq_pkg.sv - shared types and ALU function codes for the k12a ALU sequencer
package k12a_alu_seq_pkg;

  typedef enum logic [1:0] {
    ALU_SEQ_OP_ASR_N = 2'd0,
    ALU_SEQ_OP_MUL   = 2'd1
  } alu_seq_op_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ASR     = 3'd1,
    ST_MUL_ADD = 3'd2,
    ST_MUL_DBL = 3'd3,
    ST_DONE    = 3'd4
  } alu_seq_state_t;

  typedef enum logic {
    ALU_OPERAND_SEL_B   = 1'b0,
    ALU_OPERAND_SEL_IMM = 1'b1
  } alu_operand_sel_t;

  localparam logic [2:0] ALU_FN_PASS = 3'd0;
  localparam logic [2:0] ALU_FN_ADD  = 3'd4;
  localparam logic [2:0] ALU_FN_ASR  = 3'd6;

endpackage

// File: rtl/k12a_alu_seq_mplr.sv
// rtl/k12a_alu_seq_mplr.sv - multiplier shift register and 3-bit step counter
// Remaining-zero flag exists only when K12A_ALU_SEQ_EARLY_EXIT_EN is defined.
module k12a_alu_seq_mplr (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_load,
  input  logic [7:0] i_mplr,
  input  logic       i_shift,
  output logic       o_bit,
`ifdef K12A_ALU_SEQ_EARLY_EXIT_EN
  output logic       o_rest_zero,
`endif
  output logic       o_last_step
);

  logic [7:0] r_mplr;
  logic [2:0] r_step;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_mplr <= 8'd0;
      r_step <= 3'd0;
    end else if (i_load) begin
      r_mplr <= i_mplr;
      r_step <= 3'd0;
    end else if (i_shift) begin
      r_mplr <= {1'b0, r_mplr[7:1]};
      r_step <= r_step + 3'd1;
    end
  end

  assign o_bit       = r_mplr[0];
  assign o_last_step = (r_step == 3'd7);
`ifdef K12A_ALU_SEQ_EARLY_EXIT_EN
  assign o_rest_zero = (r_mplr[7:1] == 7'd0);
`endif

endmodule

// File: rtl/k12a_alu_seq.sv
// rtl/k12a_alu_seq.sv - multi-cycle ASR-by-N and shift-and-add multiply sequencer for the k12a ALU
// Optional MUL early exit: K12A_ALU_SEQ_EARLY_EXIT_EN.
module k12a_alu_seq
  import k12a_alu_seq_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic             rsp_err,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [2:0]       alu_fn,
  output alu_operand_sel_t alu_operand_sel,
  output logic             alu_load,
  input  logic [7:0]       alu_result
);

  alu_seq_state_t r_state;
  alu_seq_state_t w_state_nxt;

  logic [7:0] r_acc;
  logic [7:0] r_mcand;
  logic [7:0] r_prod;
  logic [2:0] r_cnt;
  logic [7:0] r_rsp_data;
  logic       r_rsp_err;

  logic w_accept;
  logic w_bit;
  logic w_last_step;
`ifdef K12A_ALU_SEQ_EARLY_EXIT_EN
  logic w_rest_zero;
`endif

  assign w_accept        = cmd_valid && (r_state == ST_IDLE);
  assign cmd_ready       = (r_state == ST_IDLE);
  assign rsp_valid       = (r_state == ST_DONE);
  assign rsp_data        = r_rsp_data;
  assign rsp_err         = r_rsp_err;
  assign alu_operand_sel = ALU_OPERAND_SEL_B;

  k12a_alu_seq_mplr u_mplr (
    .i_clock     (clock),
    .i_reset_n   (reset_n),
    .i_load      (w_accept),
    .i_mplr      (cmd_b),
    .i_shift     (r_state == ST_MUL_DBL),
    .o_bit       (w_bit),
`ifdef K12A_ALU_SEQ_EARLY_EXIT_EN
    .o_rest_zero (w_rest_zero),
`endif
    .o_last_step (w_last_step)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // ALU drive is decoded only from registered state so it cannot glitch on input changes.
  always_comb begin
    w_state_nxt = r_state;
    alu_a       = 8'd0;
    alu_b       = 8'd0;
    alu_fn      = ALU_FN_PASS;
    alu_load    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            ALU_SEQ_OP_ASR_N: w_state_nxt = (cmd_b[2:0] == 3'd0) ? ST_DONE : ST_ASR;
`ifdef K12A_ALU_SEQ_EARLY_EXIT_EN
            ALU_SEQ_OP_MUL:   w_state_nxt = (cmd_b == 8'd0) ? ST_DONE : ST_MUL_ADD;
`else
            ALU_SEQ_OP_MUL:   w_state_nxt = ST_MUL_ADD;
`endif
            default:          w_state_nxt = ST_DONE;
          endcase
        end
      end
      ST_ASR: begin
        alu_a    = r_acc;
        alu_fn   = ALU_FN_ASR;
        alu_load = 1'b1;
        if (r_cnt == 3'd1) w_state_nxt = ST_DONE;
      end
      ST_MUL_ADD: begin
        alu_a    = r_prod;
        alu_b    = r_mcand;
        alu_fn   = w_bit ? ALU_FN_ADD : ALU_FN_PASS;
        alu_load = 1'b1;
`ifdef K12A_ALU_SEQ_EARLY_EXIT_EN
        w_state_nxt = w_rest_zero ? ST_DONE : ST_MUL_DBL;
`else
        w_state_nxt = ST_MUL_DBL;
`endif
      end
      ST_MUL_DBL: begin
        alu_a       = r_mcand;
        alu_b       = r_mcand;
        alu_fn      = ALU_FN_ADD;
        alu_load    = 1'b1;
        w_state_nxt = w_last_step ? ST_DONE : ST_MUL_ADD;
      end
      ST_DONE: begin
        if (rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The product only changes on ADD steps, so the response tracks the latest ADD or ASR result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_acc      <= 8'd0;
      r_mcand    <= 8'd0;
      r_prod     <= 8'd0;
      r_cnt      <= 3'd0;
      r_rsp_data <= 8'd0;
      r_rsp_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_acc      <= cmd_a;
            r_mcand    <= cmd_a;
            r_prod     <= 8'd0;
            r_cnt      <= cmd_b[2:0];
            r_rsp_data <= cmd_a;
            r_rsp_err  <= (cmd_op != ALU_SEQ_OP_ASR_N) && (cmd_op != ALU_SEQ_OP_MUL);
`ifdef K12A_ALU_SEQ_EARLY_EXIT_EN
            if ((cmd_op == ALU_SEQ_OP_MUL) && (cmd_b == 8'd0)) r_rsp_data <= 8'd0;
`endif
          end
        end
        ST_ASR: begin
          r_acc      <= alu_result;
          r_cnt      <= r_cnt - 3'd1;
          r_rsp_data <= alu_result;
        end
        ST_MUL_ADD: begin
          r_prod     <= alu_result;
          r_rsp_data <= alu_result;
        end
        ST_MUL_DBL: begin
          r_mcand <= alu_result;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_k12a_alu_seq.sv
// tb/tb_k12a_alu_seq.sv - self-checking bench for k12a_alu_seq with ALU model and reference results
module tb_k12a_alu_seq;
  import k12a_alu_seq_pkg::*;

  logic             clock = 1'b0;
  logic             reset_n = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'd0;
  logic [7:0]       cmd_a = 8'd0;
  logic [7:0]       cmd_b = 8'd0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [7:0]       rsp_data;
  logic             rsp_err;
  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic [2:0]       alu_fn;
  alu_operand_sel_t alu_operand_sel;
  logic             alu_load;
  logic [7:0]       alu_result;

  int total = 0;
  int passed = 0;
  int failed = 0;
  logic [7:0] last_data;

  always #5 clock = ~clock;

  k12a_alu_seq dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_a           (cmd_a),
    .cmd_b           (cmd_b),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_data        (rsp_data),
    .rsp_err         (rsp_err),
    .alu_a           (alu_a),
    .alu_b           (alu_b),
    .alu_fn          (alu_fn),
    .alu_operand_sel (alu_operand_sel),
    .alu_load        (alu_load),
    .alu_result      (alu_result)
  );

  // Combinational k12a ALU: pass, add, arithmetic shift right by one.
  always_comb begin
    case (alu_fn)
      3'd4:    alu_result = alu_a + alu_b;
      3'd6:    alu_result = {alu_a[7], alu_a[7:1]};
      default: alu_result = alu_a;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] data, output logic err, output int lat);
    logic signed [7:0] sa;
    int msb;
    sa  = a;
    err = 1'b0;
    case (op)
      2'd0: begin
        data = sa >>> b[2:0];
        lat  = int'(b[2:0]);
      end
      2'd1: begin
        data = 8'((int'(a) * int'(b)) % 256);
`ifdef K12A_ALU_SEQ_EARLY_EXIT_EN
        msb = -1;
        for (int i = 0; i < 8; i++) if (b[i]) msb = i;
        lat = (msb < 0) ? 0 : 2 * msb + 1;
`else
        msb = 0;
        lat = 16 + msb;
`endif
      end
      default: begin
        data = a;
        err  = 1'b1;
        lat  = 0;
      end
    endcase
  endtask

  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] b, input int hold, input bit keep_valid);
    logic [7:0] exp_data;
    logic       exp_err;
    int exp_lat;
    int lat;
    int loads;
    int asr_fn_ok;
    int idle_fn_bad;
    model(op, a, b, exp_data, exp_err, exp_lat);
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    rsp_ready = 1'b0;
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    @(posedge clock);
    @(negedge clock);
    if (!keep_valid) cmd_valid = 1'b0;
    lat = 0; loads = 0; asr_fn_ok = 0; idle_fn_bad = 0;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      if (alu_load === 1'b1) begin
        loads++;
        if (alu_fn === 3'd6) asr_fn_ok++;
      end else if (alu_fn !== 3'd0) begin
        idle_fn_bad++;
      end
      @(negedge clock);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_data"}, 32'(rsp_data), 32'(exp_data));
    chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    chk({tag, "_steps"}, 32'(loads), 32'(exp_lat));
    if (op == 2'd0) chk({tag, "_asr_fn"}, 32'(asr_fn_ok), 32'(exp_lat));
    chk({tag, "_idle_fn"}, 32'(idle_fn_bad), 32'd0);
    last_data = rsp_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_hold_data"}, 32'(rsp_data), 32'(exp_data));
      chk({tag, "_hold_ready"}, 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    chk({tag, "_released"}, {30'd0, rsp_valid, cmd_ready}, 32'b01);
  endtask

  initial begin
    logic [1:0] r_op;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp", {29'd0, rsp_valid, rsp_err, alu_load}, 32'd0);
    chk("rst_data", 32'(rsp_data), 32'd0);
    chk("rst_alu", {8'd0, alu_a, alu_b, 5'd0, alu_fn}, 32'd0);
    chk("operand_sel", 32'(alu_operand_sel), 32'(ALU_OPERAND_SEL_B));
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    run_cmd("asr_80_3", 2'd0, 8'h80, 8'h03, 0, 1'b0);
    chk("asr_80_3_const", 32'(last_data), 32'hF0);
    run_cmd("asr_5a_0", 2'd0, 8'h5A, 8'h00, 0, 1'b0);
    chk("asr_5a_0_const", 32'(last_data), 32'h5A);
    run_cmd("asr_7f_7", 2'd0, 8'h7F, 8'hFF, 0, 1'b0);
    run_cmd("mul_0d_0b", 2'd1, 8'h0D, 8'h0B, 0, 1'b0);
    chk("mul_0d_0b_const", 32'(last_data), 32'h8F);
    run_cmd("mul_10_20", 2'd1, 8'h10, 8'h20, 0, 1'b0);
    chk("mul_10_20_const", 32'(last_data), 32'h00);
    run_cmd("mul_ff_ff", 2'd1, 8'hFF, 8'hFF, 0, 1'b0);
    chk("mul_ff_ff_const", 32'(last_data), 32'h01);
    run_cmd("mul_x_0", 2'd1, 8'h5C, 8'h00, 0, 1'b0);
    run_cmd("mul_hold", 2'd1, 8'h03, 8'h07, 5, 1'b1);
    run_cmd("op2", 2'd2, 8'hA7, 8'h12, 0, 1'b0);
    run_cmd("op3", 2'd3, 8'h3C, 8'h00, 2, 1'b0);
    run_cmd("asr_after_err", 2'd0, 8'hC4, 8'h02, 0, 1'b0);

    @(negedge clock);
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_a = 8'h37; cmd_b = 8'hFF;
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    repeat (4) @(posedge clock);
    #2;
    chk("mid_mul_load", 32'(alu_load), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_rst", {29'd0, alu_load, rsp_valid, cmd_ready}, 32'b001);
    chk("async_rst_alu", {8'd0, alu_a, alu_b, 5'd0, alu_fn}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    chk("post_rst_data", {23'd0, rsp_err, rsp_data}, 32'd0);
    run_cmd("after_rst", 2'd1, 8'h09, 8'h06, 0, 1'b0);

    for (int t = 0; t < 24; t++) begin
      r_op = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      run_cmd($sformatf("rnd%0d", t), r_op, 8'($urandom), 8'($urandom),
              int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
